// File: rtl/yutorina_muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide beside the EX ALU: done arrives WIDTH+1 cycles after accept (1 for divide-by-zero).
// Signed operation exists only with YUTORINA_MULDIV_SIGNED_EN; stall_req holds the pipeline from request until the result is ready.
module yutorina_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] lhs_mag, rhs_mag;
  logic             neg_in;

`ifdef YUTORINA_MULDIV_SIGNED_EN
  logic lhs_neg, rhs_neg;

  // Remainder follows the dividend sign; every other op follows the sign of the product/quotient.
  always_comb begin
    lhs_neg = sign & lhs[WIDTH-1];
    rhs_neg = sign & rhs[WIDTH-1];
    lhs_mag = lhs_neg ? -lhs : lhs;
    rhs_mag = rhs_neg ? -rhs : rhs;
    neg_in  = (op == 2'b11) ? lhs_neg : (lhs_neg ^ rhs_neg);
  end
`else
  logic unused_sign;

  always_comb begin
    lhs_mag = lhs;
    rhs_mag = rhs;
    neg_in  = 1'b0;
  end

  assign unused_sign = sign ^ neg_q;
`endif

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] hi_n, lo_n;

  // One iteration: multiply keeps {hi,lo} as the growing product with the multiplier
  // draining out of lo; divide shifts the dividend out of lo into the partial remainder
  // and shifts quotient bits back in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    if (op_q[1]) begin
      hi_n = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin;

  always_comb begin
    prod = {hi_n, lo_n};
    quo  = lo_n;
    rem  = hi_n;
`ifdef YUTORINA_MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -{hi_n, lo_n};
      quo  = -lo_n;
      rem  = -hi_n;
    end
`endif
    case (op_q)
      2'b00:   fin = prod[WIDTH-1:0];
      2'b01:   fin = prod[2*WIDTH-1:WIDTH];
      2'b10:   fin = quo;
      default: fin = rem;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    op_d       = op_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          neg_d   = neg_in;
          count_d = '0;
          hi_d    = '0;
          if (op[1] && (rhs == '0)) begin
            // Divide-by-zero resolves straight from the raw inputs.
            state_d    = S_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
            result_d   = op[0] ? lhs : '1;
          end else begin
            state_d = S_CALC;
            lo_d    = op[1] ? lhs_mag : rhs_mag;
            opnd_d  = op[1] ? rhs_mag : lhs_mag;
          end
        end
      end
      S_CALC: begin
        hi_d    = hi_n;
        lo_d    = lo_n;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = fin;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      result_d   = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      op_q       <= 2'b00;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall_req = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_CALC);
  assign done      = done_q;
  assign result    = result_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_yutorina_muldiv_ctrl.sv
// Bench for yutorina_muldiv_ctrl: directed and random ops against an arithmetic reference model.
module tb_yutorina_muldiv_ctrl;

  localparam int W = 32;
`ifdef YUTORINA_MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         sign = 1'b0;
  logic [W-1:0] lhs = '0;
  logic [W-1:0] rhs = '0;
  logic         flush = 1'b0;
  logic         busy, stall_req, done, div_zero;
  logic [W-1:0] result;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] last_res = '0;

  always #5 clk = ~clk;

  yutorina_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .sign      (sign),
    .lhs       (lhs),
    .rhs       (rhs),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: 64-bit product, truncating division.
  function automatic void model(input logic [1:0] o, input logic sg, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r, output logic dz);
    longint     sa, sb, q, rm;
    logic [63:0] p;
    bit         s;
    s  = SIGNED_EN && sg;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    dz = o[1] && (b == 0);
    if (dz) begin
      r = o[0] ? a : 32'hFFFF_FFFF;
    end else if (!o[1]) begin
      p = 64'(sa * sb);
      r = o[0] ? p[63:32] : p[31:0];
    end else begin
      q  = sa / sb;
      rm = sa % sb;
      r  = o[0] ? rm[31:0] : q[31:0];
    end
  endfunction

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input logic [1:0] o, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hold, input string tag);
    logic [W-1:0] exp_res;
    logic         exp_dz;
    int           lat, stalls, exp_lat;
    model(o, sg, a, b, exp_res, exp_dz);
    exp_lat = exp_dz ? 1 : 33;
    op = o; sign = sg; lhs = a; rhs = b; start = 1'b1;
    #1;
    chk({tag, "_stall_req"}, stall_req, 1);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lhs = $urandom; rhs = $urandom; op = 2'($urandom);
    lat = 1; stalls = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (stall_req === 1'b1) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall_cycles"}, stalls, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_div_zero"}, div_zero, exp_dz);
    chk({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_held"}, result, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_result", result, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 1'b0, 32'd7, 32'd6, 1'b0, "mul_7x6");
    run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh_u");
    run_op(2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulh_s");
    run_op(2'b10, 1'b1, -32'sd7, 32'd2, 1'b0, "div_m7_2");
    run_op(2'b11, 1'b1, -32'sd7, 32'd2, 1'b0, "rem_m7_2");
    run_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(2'b10, 1'b0, 32'd100, 32'd0, 1'b0, "div_zero");
    run_op(2'b11, 1'b0, 32'd100, 32'd0, 1'b0, "rem_zero");

    run_op(2'b00, 1'b0, 32'd12345, 32'd678, 1'b1, "hold_start");
    run_op(2'b10, 1'b0, 32'd1000, 32'd7, 1'b0, "back_to_back");

    op = 2'b00; sign = 1'b0; lhs = 32'd9; rhs = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_result", result, last_res);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("flush_no_done", seen, 0);

    start = 1'b1; flush = 1'b1; op = 2'b10; rhs = 32'd0;
    #1;
    chk("flush_start_stall", stall_req, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);
    chk("flush_start_done", done, 0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      run_op(ro, 1'($urandom_range(0, 1)), ra, rb, 1'b0, $sformatf("rand%0d", i));
    end

    op = 2'b11; sign = 1'b1; lhs = 32'd500; rhs = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_div_zero", div_zero, 0);
    chk("midrst_result", result, 0);
    chk("midrst_stall", stall_req, 0);

    run_op(2'b00, 1'b0, 32'd3, 32'd5, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
